// File: rtl/shifter_arbiter.sv
// shifter_arbiter: shares one 32-bit barrel shifter between the ALU shift
// path (port 0) and the load/store alignment path (port 1).
// Results land in a single registered slot that is tagged with its owner.
// The default build uses round-robin arbitration.
// Defining SHIFTER_ARB_FIXED_PRIO_EN makes port 0 always win contention.
module shifter_arbiter #(
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [31:0] i_req0_data,
  input  logic [4:0]  i_req0_amt,
  input  logic        i_req0_dir,
  input  logic        i_req0_arith,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [31:0] i_req1_data,
  input  logic [4:0]  i_req1_amt,
  input  logic        i_req1_dir,
  input  logic        i_req1_arith,
  output logic        o_rsp0_valid,
  input  logic        i_rsp0_ready,
  output logic        o_rsp1_valid,
  input  logic        i_rsp1_ready,
  output logic [31:0] o_rsp_data
);

  // Barrel shift. The arith flag only matters for right shifts.
  function automatic logic [31:0] do_shift(input logic [31:0] d, input logic [4:0] a,
                                           input logic dir, input logic arith);
    logic [31:0] r;
    if (!dir)       r = d << a;
    else if (arith) r = 32'($signed(d) >>> a);
    else            r = d >> a;
    return r;
  endfunction

  logic        rsp_full_q, rsp_full_d;
  logic        rsp_owner_q, rsp_owner_d;
  logic [31:0] rsp_data_q, rsp_data_d;
`ifndef SHIFTER_ARB_FIXED_PRIO_EN
  logic        prio_q, prio_d;
`endif

  logic        grant0, grant1;
  logic        owner_ready, slot_free;
  logic        acc0, acc1, acc;
  logic [31:0] sel_data;
  logic [4:0]  sel_amt;
  logic        sel_dir, sel_arith;

  // Pick which requester gets the shifter this cycle.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
`ifdef SHIFTER_ARB_FIXED_PRIO_EN
      grant0 = 1'b1;
`else
      if (prio_q) grant1 = 1'b1;
      else        grant0 = 1'b1;
`endif
    end else if (i_req0_valid) begin
      grant0 = 1'b1;
    end else if (i_req1_valid) begin
      grant1 = 1'b1;
    end
  end

  // The slot can accept when it is empty or its owner drains it this cycle.
  // Nothing is accepted while reset is asserted.
  always_comb begin
    owner_ready  = rsp_owner_q ? i_rsp1_ready : i_rsp0_ready;
    slot_free    = !rsp_full_q || owner_ready;
    o_req0_ready = grant0 && slot_free && i_rst_n;
    o_req1_ready = grant1 && slot_free && i_rst_n;
    acc0         = i_req0_valid && o_req0_ready;
    acc1         = i_req1_valid && o_req1_ready;
    acc          = acc0 || acc1;
    o_rsp0_valid = rsp_full_q && !rsp_owner_q;
    o_rsp1_valid = rsp_full_q && rsp_owner_q;
    o_rsp_data   = rsp_data_q;
  end

  // Steer the granted port's operands into the shared shifter.
  always_comb begin
    sel_data  = grant1 ? i_req1_data  : i_req0_data;
    sel_amt   = grant1 ? i_req1_amt   : i_req0_amt;
    sel_dir   = grant1 ? i_req1_dir   : i_req0_dir;
    sel_arith = grant1 ? i_req1_arith : i_req0_arith;
  end

  // Next state of the result slot and of the round-robin pointer.
  always_comb begin
    rsp_full_d  = rsp_full_q;
    rsp_owner_d = rsp_owner_q;
    rsp_data_d  = rsp_data_q;
    if (rsp_full_q && owner_ready) rsp_full_d = 1'b0;
    if (acc) begin
      rsp_full_d  = 1'b1;
      rsp_owner_d = acc1;
      rsp_data_d  = do_shift(sel_data, sel_amt, sel_dir, sel_arith);
    end
`ifndef SHIFTER_ARB_FIXED_PRIO_EN
    prio_d = prio_q;
    if (acc) prio_d = !acc1;
`endif
  end

  // State registers. Reset drops any held result.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rsp_full_q  <= 1'b0;
      rsp_owner_q <= 1'b0;
      rsp_data_q  <= 32'h0;
`ifndef SHIFTER_ARB_FIXED_PRIO_EN
      prio_q      <= INIT_PRIO;
`endif
    end else begin
      rsp_full_q  <= rsp_full_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_data_q  <= rsp_data_d;
`ifndef SHIFTER_ARB_FIXED_PRIO_EN
      prio_q      <= prio_d;
`endif
    end
  end

endmodule
